reg_writeback_unit: RTL and testbench

Write-back stage of the 16-bit RISC core, directly upstream of the register file's eight 16-bit registers. It accepts destination-register write requests from the ALU and the load unit over valid/ready handshakes and buffers them in a small FIFO. It drains one write per cycle as a one-hot register write-enable plus a shared data bus. It also exports per-register busy bits for hazard detection in decode.

---
 rtl/reg_writeback_unit_pkg.sv | 10 +
 rtl/reg_writeback_unit_wb_fifo.sv | 38 +++
 rtl/reg_writeback_unit.sv | 67 ++++++
 tb/tb_reg_writeback_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/reg_writeback_unit_pkg.sv
// reg_writeback_unit_pkg: shared core constants (REG_W, NREG, RADDR_W) and the {rd,data} write-request struct
package reg_writeback_unit_pkg;
  localparam int REG_W = 16;
  localparam int NREG = 8;
  localparam int RADDR_W = 3;
  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic [REG_W-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/reg_writeback_unit_wb_fifo.sv
// wb_fifo: circular-buffer FIFO; push/pop/din in, head/full/empty out (push ignored when full, pop ignored when empty)
module wb_fifo #(
  parameter int W = 19,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          wr, rd;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      cnt <= cnt + CW'(wr) - CW'(rd);
    end
  end
  always_ff @(posedge clk) if (wr) mem[wp] <= din;
endmodule

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: arbitrates alu/mem write requests (mem first) into wb_fifo, drains one-hot wr_en/wr_data, exports busy/full/empty
module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NREG = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [$clog2(NREG)-1:0]  alu_rd,
  input  logic [REG_W-1:0]         alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [$clog2(NREG)-1:0]  mem_rd,
  input  logic [REG_W-1:0]         mem_data,
  output logic                     mem_ready,
  input  logic                     drain_en,
  output logic [NREG-1:0]          wr_en,
  output logic [REG_W-1:0]         wr_data,
  output logic [NREG-1:0]          busy,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(NREG);
  localparam int PW = $clog2(DEPTH + 2);
  logic                push, pop;
  logic [AW-1:0]       in_rd, head_rd;
  logic [REG_W-1:0]    in_data, head_data;
  logic [AW+REG_W-1:0] head;
  logic [NREG-1:0]     inc;
  logic [PW-1:0]       pend [NREG];
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign push = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign pop = drain_en && !empty;
  assign in_rd = mem_valid ? mem_rd : alu_rd;
  assign in_data = mem_valid ? mem_data : alu_data;
  assign inc = push ? NREG'(1) << in_rd : '0;
  assign head_rd = head[AW+REG_W-1:REG_W];
  assign head_data = head[REG_W-1:0];
  wb_fifo #(.W(AW + REG_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({in_rd, in_data}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= pop ? NREG'(1) << head_rd : '0;
      if (pop) wr_data <= head_data;
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NREG; i++)
      pend[i] <= rst ? '0 : pend[i] + PW'(inc[i]) - PW'(wr_en[i]);
  for (genvar r = 0; r < NREG; r++) begin : g_busy
    assign busy[r] = |pend[r];
  end
endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb_reg_writeback_unit: directed and random stimulus checked against a queue-based write-back model
module tb_reg_writeback_unit;
  import reg_writeback_unit_pkg::*;
  localparam int DEPTH = 4;
  logic        clk = 0, rst = 1, alu_valid = 0, mem_valid = 0, drain_en = 0;
  logic [2:0]  alu_rd = 0, mem_rd = 0;
  logic [15:0] alu_data = 0, mem_data = 0;
  logic        alu_ready, mem_ready, full, empty;
  logic [7:0]  wr_en, busy;
  logic [15:0] wr_data;
  wb_req_t     q[$];
  logic [7:0]  m_wr_en = 0;
  logic [15:0] m_wr_data = 0;
  int          checks = 0, failures = 0;
  always #5 clk = ~clk;
  reg_writeback_unit #(.DEPTH(DEPTH), .NREG(8)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .drain_en(drain_en), .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .full(full), .empty(empty)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    logic [7:0] eb;
    bit         room, acc_m, acc_a, pop;
    wb_req_t    h;
    #1;
    room = q.size() < DEPTH;
    eb = m_wr_en;
    foreach (q[i]) eb[q[i].rd] = 1'b1;
    chk("mem_ready", mem_ready, room);
    chk("alu_ready", alu_ready, room && !mem_valid);
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0);
    chk("busy", busy, eb);
    chk("wr_en", wr_en, m_wr_en);
    chk("wr_data", wr_data, m_wr_data);
    acc_m = mem_valid && room;
    acc_a = alu_valid && !mem_valid && room;
    pop = drain_en && q.size() > 0;
    if (rst) begin
      q.delete();
      m_wr_en = 0;
      m_wr_data = 0;
    end else begin
      m_wr_en = 0;
      if (pop) begin
        h = q.pop_front();
        m_wr_en = 8'(1) << h.rd;
        m_wr_data = h.data;
      end
      if (acc_m) q.push_back('{mem_rd, mem_data});
      else if (acc_a) q.push_back('{alu_rd, alu_data});
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    cyc();
    // basic write
    drain_en = 1; alu_valid = 1; alu_rd = 3; alu_data = 16'h1234;
    cyc();
    alu_valid = 0;
    chk("basic_busy3_n1", busy[3], 1);
    cyc();
    chk("basic_wr_en", wr_en, 8'h08);
    chk("basic_wr_data", wr_data, 16'h1234);
    cyc();
    chk("basic_busy3_n3", busy[3], 0);
    cyc();
    // priority
    alu_valid = 1; alu_rd = 1; alu_data = 16'hAAAA;
    mem_valid = 1; mem_rd = 2; mem_data = 16'h5555;
    #1;
    chk("prio_alu_ready", alu_ready, 0);
    cyc();
    mem_valid = 0;
    cyc();
    alu_valid = 0;
    chk("prio_first_r2", wr_en, 8'h04);
    cyc();
    chk("prio_then_r1", wr_en, 8'h02);
    chk("prio_data", wr_data, 16'hAAAA);
    cyc();
    // full and wrap-around
    drain_en = 0;
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1; alu_rd = 3'(i); alu_data = 16'(16'h100 + i);
      if (i == 4) begin
        #1;
        chk("full_at_4", full, 1);
        chk("full_alu_ready", alu_ready, 0);
      end
      cyc();
    end
    drain_en = 1;
    for (int k = 0; k < 8; k++) begin
      alu_valid = k < 2;
      if (k >= 1 && k <= 5) chk("wrap_order", wr_en, 8'(1) << (k - 1));
      cyc();
    end
    // same-register ordering
    drain_en = 0;
    alu_valid = 1; alu_rd = 5; alu_data = 16'h0001;
    cyc();
    alu_data = 16'h0002;
    cyc();
    alu_valid = 0; drain_en = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) chk("same_reg_busy_between", busy[5], 1);
      if (k == 2) chk("same_reg_final", wr_data, 16'h0002);
      cyc();
    end
    chk("same_reg_busy_done", busy[5], 0);
    // reset mid-operation
    drain_en = 0;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1; mem_rd = 3'(6 - i); mem_data = 16'($urandom);
      cyc();
    end
    rst = 1; drain_en = 1;
    cyc();
    rst = 0; mem_valid = 0;
    chk("rst_empty", empty, 1);
    chk("rst_busy", busy, 8'h00);
    for (int k = 0; k < 5; k++) begin
      chk("rst_no_write", wr_en, 8'h00);
      cyc();
    end
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst = $urandom_range(0, 60) == 0;
      alu_valid = 1'($urandom);
      alu_rd = 3'($urandom);
      alu_data = 16'($urandom);
      mem_valid = $urandom_range(0, 2) == 0;
      mem_rd = 3'($urandom);
      mem_data = 16'($urandom);
      drain_en = $urandom_range(0, 3) != 0;
      cyc();
    end
    rst = 0; alu_valid = 0; mem_valid = 0; drain_en = 1;
    for (int k = 0; k < 8; k++) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
